// File: rtl/md5_pkg.sv
// Shared MD5 definitions: padder FSM states, pad image modes, block geometry
// constants and the byte bit-reverse helper that the block core also uses.
package md5_pkg;

  localparam int         MD5_BLOCK_BYTES = 64;
  localparam int         MD5_LEN_OFFSET  = 56;
  localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    EMIT,
    EXTRA
  } pad_state_e;

  // What the pad builder lays over the buffered bytes
  typedef enum logic [2:0] {
    PM_PASS,      // buffer as-is (full data block)
    PM_FINAL,     // 0x80 at c, zero fill, length in bytes 56..63
    PM_TERM,      // 0x80 at c, zero fill to end, length goes in an extra block
    PM_EXTRA_80,  // extra block that still needs the terminator at byte 0
    PM_EXTRA      // extra block, terminator already sent
  } pad_mode_e;

  function automatic logic [7:0] md5_bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/md5_pad_builder.sv
// Combinational builder of the padded 64-byte block image from the buffered
// bytes, the fill count c and the running bit length.
module md5_pad_builder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic [MD5_BLOCK_BYTES-1:0][7:0] mem_i,
  input  logic [6:0]                      c_i,
  input  logic [LEN_W-1:0]                len_i,
  input  pad_mode_e                       mode_i,
  output logic [MD5_BLOCK_BYTES-1:0][7:0] img_o
);

  logic [7:0][7:0] len_b;

  // Length field is always 64 bits wide; narrow test counters zero-fill the top
  always_comb begin
    len_b              = '0;
    len_b[LEN_W/8-1:0] = len_i;
  end

  // Per-byte select between data, terminator, zero fill and length bytes
  always_comb begin
    img_o = '0;
    for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
      unique case (mode_i)
        PM_PASS:  img_o[k] = mem_i[k];
        PM_FINAL: begin
          if (7'(k) < c_i)            img_o[k] = mem_i[k];
          else if (7'(k) == c_i)      img_o[k] = MD5_PAD_BYTE;
          else if (k >= MD5_LEN_OFFSET) img_o[k] = len_b[3'(k)];
          else                        img_o[k] = 8'h00;
        end
        PM_TERM: begin
          if (7'(k) < c_i)            img_o[k] = mem_i[k];
          else if (7'(k) == c_i)      img_o[k] = MD5_PAD_BYTE;
          else                        img_o[k] = 8'h00;
        end
        PM_EXTRA_80, PM_EXTRA: begin
          if (k >= MD5_LEN_OFFSET)    img_o[k] = len_b[3'(k)];
          else if (k == 0 && mode_i == PM_EXTRA_80) img_o[k] = MD5_PAD_BYTE;
          else                        img_o[k] = 8'h00;
        end
        default:  img_o[k] = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/md5_msg_padder.sv
// MD5 message padder: byte stream in, padded 512-bit blocks out with
// first/last flags for the block core.
// Build option: MD5_PAD_BITREV_EN bit-reverses every output byte lane so the
// block core can consume blk_data directly; default is natural bit order.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  input  logic         in_empty,
  output logic         in_ready,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         blk_first,
  output logic         blk_last
);

  pad_state_e                       state_q, state_d;
  logic [6:0]                       idx_q, idx_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [MD5_BLOCK_BYTES-1:0][7:0]  mem_q, mem_d;
  logic [MD5_BLOCK_BYTES-1:0][7:0]  blk_q, blk_d;
  logic                             blk_first_q, blk_first_d;
  logic                             blk_last_q, blk_last_d;
  logic                             first_pend_q, first_pend_d;
  logic                             need_extra_q, need_extra_d;
  logic                             term_done_q, term_done_d;

  pad_mode_e                        mode;
  logic [MD5_BLOCK_BYTES-1:0][7:0]  img;

  // The builder sees the buffer including this cycle's byte, so byte 63 can
  // be captured into the output block on the same edge it is accepted.
  md5_pad_builder #(.LEN_W(LEN_W)) u_builder (
    .mem_i  (mem_d),
    .c_i    (idx_q),
    .len_i  (len_q),
    .mode_i (mode),
    .img_o  (img)
  );

  // Next-state: buffer fill, padding decisions and output handshake
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    mem_d        = mem_q;
    blk_d        = blk_q;
    blk_first_d  = blk_first_q;
    blk_last_d   = blk_last_q;
    first_pend_d = first_pend_q;
    need_extra_d = need_extra_q;
    term_done_d  = term_done_q;
    mode         = PM_PASS;

    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          if (!in_empty) begin
            mem_d[idx_q[5:0]] = in_data;
            idx_d             = idx_q + 7'd1;
            len_d             = len_q + LEN_W'(8);
          end
          if (in_last) begin
            state_d = PAD;
          end else if (!in_empty && idx_q == 7'd63) begin
            state_d      = EMIT;
            blk_d        = img;
            blk_first_d  = first_pend_q;
            blk_last_d   = 1'b0;
            need_extra_d = 1'b0;
          end
        end
      end
      PAD: begin
        state_d     = EMIT;
        blk_first_d = first_pend_q;
        if (idx_q <= 7'd55) begin
          mode         = PM_FINAL;
          blk_last_d   = 1'b1;
          need_extra_d = 1'b0;
        end else if (idx_q <= 7'd63) begin
          // No room for the length: terminator now, length in an extra block
          mode         = PM_TERM;
          blk_last_d   = 1'b0;
          need_extra_d = 1'b1;
          term_done_d  = 1'b1;
        end else begin
          // Buffer exactly full: send data, terminator goes in the extra block
          mode         = PM_PASS;
          blk_last_d   = 1'b0;
          need_extra_d = 1'b1;
          term_done_d  = 1'b0;
        end
        blk_d = img;
      end
      EMIT: begin
        if (blk_ready) begin
          first_pend_d = blk_last_q;
          if (need_extra_q) begin
            state_d = EXTRA;
          end else begin
            state_d = FILL;
            idx_d   = '0;
            if (blk_last_q) len_d = '0;
          end
        end
      end
      EXTRA: begin
        mode         = term_done_q ? PM_EXTRA : PM_EXTRA_80;
        blk_d        = img;
        blk_first_d  = first_pend_q;
        blk_last_d   = 1'b1;
        need_extra_d = 1'b0;
        state_d      = EMIT;
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers; reset discards any partial message
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FILL;
      idx_q        <= '0;
      len_q        <= '0;
      mem_q        <= '0;
      blk_q        <= '0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      first_pend_q <= 1'b1;
      need_extra_q <= 1'b0;
      term_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      mem_q        <= mem_d;
      blk_q        <= blk_d;
      blk_first_q  <= blk_first_d;
      blk_last_q   <= blk_last_d;
      first_pend_q <= first_pend_d;
      need_extra_q <= need_extra_d;
      term_done_q  <= term_done_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;

  // Output byte-lane mapping
  for (genvar k = 0; k < MD5_BLOCK_BYTES; k++) begin : g_lane
`ifdef MD5_PAD_BITREV_EN
    assign blk_data[8*k +: 8] = md5_bitrev8(blk_q[k]);
`else
    assign blk_data[8*k +: 8] = blk_q[k];
`endif
  end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder: a reference MD5 padding routine fills a
// scoreboard of expected blocks, a monitor pops and compares on handshake.
module tb_md5_msg_padder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0, in_last = 1'b0, in_empty = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid, blk_ready = 1'b0, blk_first, blk_last;

  md5_msg_padder #(.LEN_W(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_empty(in_empty),
    .in_ready(in_ready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  blk_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [511:0] last_blk = '0;
  int           blocks_seen = 0;

  function automatic logic [7:0] lane(input logic [7:0] b);
    logic [7:0] r;
`ifdef MD5_PAD_BITREV_EN
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
    r = b;
`endif
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [511:0] blk, input int k);
    return lane(blk[8*k +: 8]);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference padding: append 0x80, zero to 56 mod 64, 64-bit LE bit length
  task automatic push_msg(input logic [7:0] msg[$]);
    logic [7:0]  p[$];
    logic [63:0] bits;
    blk_t        e;
    int          nblk;
    p    = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 0; i < 8; i++) p.push_back(bits[8*i +: 8]);
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int k = 0; k < 64; k++) e.data[8*k +: 8] = lane(p[64*b + k]);
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat
  task automatic send(input logic [7:0] d, input logic last, input logic empty);
    int n = 0;
    in_data = d; in_last = last; in_empty = empty; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $error("FAIL send_timeout observed in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] msg[$], input int lo, input int hi, input logic last);
    for (int i = lo; i < hi; i++) send(msg[i], last && (i == hi - 1), 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed %0d pending expected 0", exp_q.size());
    end
  endtask

  // Scoreboard monitor: compare each block as it is handed over
  always @(negedge clk) begin
    blk_t e;
    if (reset_n && blk_valid && blk_ready) begin
      last_blk = blk_data;
      blocks_seen++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $error("FAIL unexpected_block observed %0h expected none", blk_data);
      end else begin
        e = exp_q.pop_front();
        chk("blk_data",  blk_data, e.data);
        chk("blk_first", 512'(blk_first), 512'(e.first));
        chk("blk_last",  512'(blk_last),  512'(e.last));
      end
    end
  end

  initial begin
    logic [7:0]   m[$];
    logic [511:0] abc_blk, snap;
    logic         snap_f, snap_l;
    int           nb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_blk_valid", 512'(blk_valid), 512'(1'b0));
    chk("rst_blk_first", 512'(blk_first), 512'(1'b0));
    chk("rst_blk_last",  512'(blk_last),  512'(1'b0));
    chk("rst_blk_data",  blk_data, 512'd0);
    chk("rst_in_ready",  512'(in_ready), 512'(1'b1));
    @(negedge clk) reset_n = 1'b1;
    blk_ready = 1'b1;
    @(posedge clk); #1;

    // "abc": single block, PAD gap then valid
    m = '{8'h61, 8'h62, 8'h63};
    push_msg(m);
    send_range(m, 0, 3, 1'b1);
    chk("abc_pad_gap", 512'(blk_valid), 512'(1'b0));
    @(posedge clk); #1;
    chk("abc_final_lat", 512'(blk_valid), 512'(1'b1));
    drain();
    abc_blk = last_blk;
    chk("abc_byte3",  512'(get_byte(last_blk, 3)),  512'(8'h80));
    chk("abc_byte56", 512'(get_byte(last_blk, 56)), 512'(8'h18));

    // Empty message
    m = {};
    push_msg(m);
    send(8'h00, 1'b1, 1'b1);
    drain();
    chk("empty_byte0",  512'(get_byte(last_blk, 0)),  512'(8'h80));
    chk("empty_byte56", 512'(get_byte(last_blk, 56)), 512'(8'h00));

    // 56 bytes: terminator fills byte 56, length in extra block
    m = {};
    for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
    push_msg(m);
    nb = blocks_seen;
    send_range(m, 0, 56, 1'b1);
    drain();
    chk("b56_nblocks", 512'(blocks_seen - nb), 512'd2);
    chk("b56_len0", 512'(get_byte(last_blk, 56)), 512'(8'hC0));
    chk("b56_len1", 512'(get_byte(last_blk, 57)), 512'(8'h01));

    // 64 bytes then empty last beat
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(8'hA0 ^ i));
    push_msg(m);
    send_range(m, 0, 64, 1'b0);
    chk("b64_full_lat", 512'(blk_valid), 512'(1'b1));
    send(8'h00, 1'b1, 1'b1);
    drain();
    chk("b64_byte0", 512'(get_byte(last_blk, 0)),  512'(8'h80));
    chk("b64_len1",  512'(get_byte(last_blk, 57)), 512'(8'h02));

    // Backpressure on first block of a 120-byte message
    blk_ready = 1'b0;
    m = {};
    for (int i = 0; i < 120; i++) m.push_back(8'($urandom_range(0, 255)));
    push_msg(m);
    send_range(m, 0, 64, 1'b0);
    snap = blk_data; snap_f = blk_first; snap_l = blk_last;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data",     blk_data, snap);
      chk("hold_first",    512'(blk_first), 512'(snap_f));
      chk("hold_last",     512'(blk_last),  512'(snap_l));
      chk("hold_in_ready", 512'(in_ready),  512'(1'b0));
      chk("hold_valid",    512'(blk_valid), 512'(1'b1));
    end
    @(posedge clk); #1;
    blk_ready = 1'b1;
    send_range(m, 64, 120, 1'b1);
    drain();

    // Reset mid-message
    m = {};
    for (int i = 0; i < 64; i++) m.push_back(8'(i * 3));
    send_range(m, 0, 20, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rstmsg_valid", 512'(blk_valid), 512'(1'b0));
    chk("rstmsg_idx",   512'(dut.idx_q), 512'd0);
    chk("rstmsg_ready", 512'(in_ready),  512'(1'b1));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-EMIT: blk_valid drops without a clock edge
    blk_ready = 1'b0;
    send_range(m, 0, 64, 1'b0);
    chk("rstemit_pre", 512'(blk_valid), 512'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    chk("rstemit_valid", 512'(blk_valid), 512'(1'b0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b1;

    // "abc" again must match the first run
    m = '{8'h61, 8'h62, 8'h63};
    push_msg(m);
    send_range(m, 0, 3, 1'b1);
    drain();
    chk("abc_repeat", last_blk, abc_blk);

    repeat (5) @(posedge clk);
    #1;
    chk("no_leftover", 512'(exp_q.size()), 512'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
